// File: rtl/perif_es_pkg.sv
// perif_es shared definitions: address map and CTRL bit layout.
package perif_es_pkg;

  localparam logic [15:0] ADDR_IN0    = 16'h0000;
  localparam logic [15:0] ADDR_OUT0   = 16'h0004;
  localparam logic [15:0] ADDR_RELOAD = 16'h0008;
  localparam logic [15:0] ADDR_COUNT  = 16'h0009;
  localparam logic [15:0] ADDR_CTRL   = 16'h000A;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_FLAG = 15;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_IN,
    SEL_OUT,
    SEL_RELOAD,
    SEL_COUNT,
    SEL_CTRL
  } sel_e;

  function automatic sel_e decode(input logic [15:0] a);
    sel_e s;
    s = SEL_NONE;
    unique case (1'b1)
      (a[15:2] == ADDR_IN0[15:2]):  s = SEL_IN;
      (a[15:2] == ADDR_OUT0[15:2]): s = SEL_OUT;
      (a == ADDR_RELOAD):           s = SEL_RELOAD;
      (a == ADDR_COUNT):            s = SEL_COUNT;
      (a == ADDR_CTRL):             s = SEL_CTRL;
      default:                      s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/perif_es_temporizador.sv
// Prescaled down-counter timer with reload, one-shot/auto-reload
// modes, sticky write-1-to-clear FLAG and registered interrupt.
module temporizador
  import perif_es_pkg::*;
#(
  parameter int PRESC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_reload_i,
  input  logic        wr_ctrl_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] reload_o,
  output logic [15:0] count_o,
  output logic [15:0] ctrl_o,
  output logic        irq_o
);

  localparam logic [15:0] PMAX = 16'(PRESC - 1);

  logic [15:0] presc_q, presc_d;
  logic [15:0] count_q, count_d;
  logic [15:0] reload_q, reload_d;
  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic        ie_q, ie_d;
  logic        flag_q, flag_d;
  logic        irq_q;
  logic        tick;
  logic        expire;
  logic        en_rise;

  // A RELOAD write takes over the whole counting path this cycle.
  assign tick    = en_q && (presc_q == PMAX) && !wr_reload_i;
  assign expire  = tick && (count_q == 16'd0);
  assign en_rise = wr_ctrl_i && wdata_i[CTRL_EN] && !en_q;

  always_comb begin
    presc_d  = presc_q;
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    ar_d     = ar_q;
    ie_d     = ie_q;
    flag_d   = flag_q;

    if (en_q) begin
      presc_d = (presc_q == PMAX) ? 16'd0 : presc_q + 16'd1;
    end

    if (tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (ar_q) begin
        count_d = reload_q;
      end
    end

    if (expire) begin
      flag_d = 1'b1;
      if (!ar_q) begin
        en_d = 1'b0;
      end
    end else if (wr_ctrl_i && wdata_i[CTRL_FLAG]) begin
      flag_d = 1'b0;
    end

    if (wr_ctrl_i) begin
      en_d = wdata_i[CTRL_EN];
      ar_d = wdata_i[CTRL_AR];
      ie_d = wdata_i[CTRL_IE];
      if (!wdata_i[CTRL_EN] && expire) begin
        count_d = count_q;
      end
      if (en_rise) begin
        presc_d = 16'd0;
      end
    end

    if (wr_reload_i) begin
      reload_d = wdata_i;
      count_d  = wdata_i;
      presc_d  = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q  <= 16'd0;
      count_q  <= 16'd0;
      reload_q <= 16'd0;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      ie_q     <= 1'b0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      ie_q     <= ie_d;
      flag_q   <= flag_d;
      irq_q    <= flag_q && ie_q;
    end
  end

  always_comb begin
    ctrl_o            = 16'd0;
    ctrl_o[CTRL_EN]   = en_q;
    ctrl_o[CTRL_AR]   = ar_q;
    ctrl_o[CTRL_IE]   = ie_q;
    ctrl_o[CTRL_FLAG] = flag_q;
  end

  assign reload_o = reload_q;
  assign count_o  = count_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/perif_es.sv
// Memory-mapped I/O block: four synchronized input ports, four
// output ports and a prescaled timer on a 16-bit data bus.
module perif_es
  import perif_es_pkg::*;
#(
  parameter int PRESC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] direcciones,
  input  logic [15:0] wdata,
  input  logic        we,
  output logic [15:0] datos,
  input  logic [63:0] ent,
  output logic [63:0] sal,
  output logic        irq
);

  logic [63:0] s1_q, s2_q;
  logic [63:0] sal_q, sal_d;
  logic [15:0] reload_w, count_w, ctrl_w;
  logic [1:0]  idx;
  sel_e        sel;

  assign sel = decode(direcciones);
  assign idx = direcciones[1:0];

  always_comb begin
    sal_d = sal_q;
    if (we && (sel == SEL_OUT)) begin
      sal_d[idx*16 +: 16] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q  <= 64'd0;
      s2_q  <= 64'd0;
      sal_q <= 64'd0;
    end else begin
      s1_q  <= ent;
      s2_q  <= s1_q;
      sal_q <= sal_d;
    end
  end

  temporizador #(
    .PRESC(PRESC)
  ) u_tmr (
    .clk        (clk),
    .rst_n      (reset),
    .wr_reload_i(we && (sel == SEL_RELOAD)),
    .wr_ctrl_i  (we && (sel == SEL_CTRL)),
    .wdata_i    (wdata),
    .reload_o   (reload_w),
    .count_o    (count_w),
    .ctrl_o     (ctrl_w),
    .irq_o      (irq)
  );

  always_comb begin
    datos = 16'd0;
    unique case (sel)
      SEL_IN:     datos = s2_q[idx*16 +: 16];
      SEL_OUT:    datos = sal_q[idx*16 +: 16];
      SEL_RELOAD: datos = reload_w;
      SEL_COUNT:  datos = count_w;
      SEL_CTRL:   datos = ctrl_w;
      default:    datos = 16'd0;
    endcase
  end

  assign sal = sal_q;

endmodule

// File: tb/tb_perif_es.sv
// Scoreboard bench for perif_es: stimulus pushes expected values,
// a negedge monitor pops and compares against the DUT.
module tb_perif_es;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] direcciones;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] datos;
  logic [63:0] ent;
  logic [63:0] sal;
  logic        irq;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  perif_es #(.PRESC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .direcciones(direcciones),
    .wdata      (wdata),
    .we         (we),
    .datos      (datos),
    .ent        (ent),
    .sal        (sal),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = {48'd0, datos};
        1:       act = sal;
        default: act = {63'd0, irq};
      endcase
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h want %h", e.name, act, e.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    direcciones = a;
    wdata       = d;
    we          = 1'b1;
    step();
    we          = 1'b0;
  endtask

  task automatic expect_now(input string n, input int s,
                            input logic [63:0] v);
    sb.push_back('{n, s, v});
  endtask

  task automatic chk_rd(input string n, input logic [15:0] a,
                        input logic [15:0] v);
    direcciones = a;
    we          = 1'b0;
    sb.push_back('{n, 0, {48'd0, v}});
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    direcciones = 16'd0;
    wdata       = 16'd0;
    we          = 1'b0;
    ent         = 64'd0;
    step();

    wr(16'h0004, 16'hAAAA);
    wr(16'h0007, 16'h5555);
    expect_now("sal_pre_reset", 1, 64'h5555_0000_0000_AAAA);
    chk_rd("rd_out0_pre", 16'h0004, 16'hAAAA);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    expect_now("sal_reset", 1, 64'd0);
    expect_now("irq_reset", 2, 64'd0);
    chk_rd("ctrl_reset", 16'h000A, 16'h0000);
    chk_rd("reload_reset", 16'h0008, 16'h0000);

    ent[15:0]  = 16'hBEEF;
    ent[63:48] = 16'h1357;
    step();
    chk_rd("sync_edge_t", 16'h0000, 16'h0000);
    step();
    chk_rd("sync_edge_t1", 16'h0000, 16'hBEEF);
    chk_rd("sync_port3", 16'h0003, 16'h1357);

    wr(16'h0005, 16'h1234);
    expect_now("sal_out1", 1, 64'h0000_0000_1234_0000);
    chk_rd("rd_out1", 16'h0005, 16'h1234);
    wr(16'h0020, 16'hFFFF);
    expect_now("sal_unmapped", 1, 64'h0000_0000_1234_0000);
    chk_rd("rd_unmapped", 16'h0020, 16'h0000);
    wr(16'h0009, 16'h00FF);
    chk_rd("count_ro", 16'h0009, 16'h0000);

    wr(16'h0008, 16'd3);
    chk_rd("reload_rd", 16'h0008, 16'd3);
    wr(16'h000A, 16'h0005);
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 15) chk_rd("os_ctrl_c15", 16'h000A, 16'h0005);
      if (i == 16) begin
        expect_now("os_irq_c16", 2, 64'd0);
        chk_rd("os_ctrl_c16", 16'h000A, 16'h8004);
      end
      if (i == 17) begin
        expect_now("os_irq_c17", 2, 64'd1);
        chk_rd("os_count_c17", 16'h0009, 16'h0000);
      end
    end

    wr(16'h000A, 16'h8000);
    chk_rd("flag_cleared", 16'h000A, 16'h0000);
    wr(16'h0008, 16'd1);
    wr(16'h000A, 16'h0007);
    repeat (7) step();
    wr(16'h000A, 16'h8007);
    chk_rd("ar_race_flag", 16'h000A, 16'h8007);
    wr(16'h000A, 16'h8007);
    expect_now("ar_irq_hi", 2, 64'd1);
    chk_rd("ar_clear_flag", 16'h000A, 16'h0007);
    step();
    expect_now("ar_irq_lo", 2, 64'd0);
    chk_rd("ar_count_reload", 16'h0009, 16'h0001);

    wr(16'h000A, 16'h8000);
    wr(16'h0008, 16'd10);
    wr(16'h000A, 16'h0001);
    repeat (20) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_rd("mid_count", 16'h0009, 16'h0000);
    chk_rd("mid_ctrl", 16'h000A, 16'h0000);
    expect_now("mid_sal", 1, 64'd0);
    chk_rd("mid_reload", 16'h0008, 16'h0000);
    repeat (100) step();
    expect_now("mid_irq_late", 2, 64'd0);
    chk_rd("mid_ctrl_late", 16'h000A, 16'h0000);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
